// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - register map, access-mode encoding and lane-merge helper for clint_timer
package clint_pkg;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_PRESCALE    = 5'h14;

  localparam int CTRL_EN_BIT = 0;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_acc_mode_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - tick divider for clint_timer, present only with CLINT_PRESCALER_EN
module clint_prescaler #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] prescale,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - memory-mapped machine timer; optional divider under CLINT_PRESCALER_EN
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [63:0] RST_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESCALE_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_interrupt
);

  logic [63:0]           mtime_q, mtimecmp_q;
  logic                  en_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [31:0]           pre_word;
  logic                  tick;

  mem_acc_mode_e mode;
  logic          wr;
  logic [2:0]    widx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [3:0]    be_mlo, be_mhi, be_clo, be_chi;
  logic          ctrl_wr, mtime_wr;

  assign mode = mem_acc_mode_e'(mem_acc_mode);
  assign wr   = sel & wr_en;
  assign widx = addr[4:2];
  assign off  = addr[1:0];

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    case (mode)
      MEM_B: begin
        be    = 4'b0001 << off;
        wword = {4{wdata[7:0]}};
      end
      MEM_H: begin
        be    = off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
        wword = {2{wdata[15:0]}};
      end
      MEM_W:   be = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: be = 4'b0000;
    endcase
  end

  assign be_mlo   = (wr && widx == OFF_MTIME_LO[4:2])    ? be : 4'b0000;
  assign be_mhi   = (wr && widx == OFF_MTIME_HI[4:2])    ? be : 4'b0000;
  assign be_clo   = (wr && widx == OFF_MTIMECMP_LO[4:2]) ? be : 4'b0000;
  assign be_chi   = (wr && widx == OFF_MTIMECMP_HI[4:2]) ? be : 4'b0000;
  assign ctrl_wr  = wr && (widx == OFF_CTRL[4:2]) && be[0];
  assign mtime_wr = |{be_mlo, be_mhi};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q         <= '0;
      mtimecmp_q      <= RST_MTIMECMP;
      en_q            <= 1'b0;
      timer_interrupt <= 1'b0;
    end else begin
      // A software write to either half wins over the tick for the whole counter.
      if (mtime_wr) begin
        mtime_q <= {merge_lanes(mtime_q[63:32], wword, be_mhi),
                    merge_lanes(mtime_q[31:0],  wword, be_mlo)};
      end else if (tick) begin
        mtime_q <= mtime_q + 64'd1;
      end
      mtimecmp_q <= {merge_lanes(mtimecmp_q[63:32], wword, be_chi),
                     merge_lanes(mtimecmp_q[31:0],  wword, be_clo)};
      if (ctrl_wr) begin
        en_q <= wword[CTRL_EN_BIT];
      end
      timer_interrupt <= en_q && (mtime_q >= mtimecmp_q);
    end
  end

`ifdef CLINT_PRESCALER_EN
  logic [3:0] be_pre;
  assign be_pre = (wr && widx == OFF_PRESCALE[4:2]) ? be : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q <= '0;
    end else begin
      for (int i = 0; i < int'(PRESCALE_W); i++) begin
        if (be_pre[i/8]) prescale_q[i] <= wword[i];
      end
    end
  end

  clint_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en_q),
    .clr      (|be_pre),
    .prescale (prescale_q),
    .tick     (tick)
  );
`else
  assign prescale_q = '0;
  assign tick       = en_q;
`endif

  always_comb begin
    pre_word                 = '0;
    pre_word[PRESCALE_W-1:0] = prescale_q;
  end

  logic [31:0] word;
  logic [15:0] shifted;

  always_comb begin
    word = '0;
    case (widx)
      OFF_MTIME_LO[4:2]:    word = mtime_q[31:0];
      OFF_MTIME_HI[4:2]:    word = mtime_q[63:32];
      OFF_MTIMECMP_LO[4:2]: word = mtimecmp_q[31:0];
      OFF_MTIMECMP_HI[4:2]: word = mtimecmp_q[63:32];
      OFF_CTRL[4:2]:        word = {31'b0, en_q};
      OFF_PRESCALE[4:2]:    word = pre_word;
      default:              word = '0;
    endcase
  end

  assign shifted = 16'(word >> {off, 3'b000});

  always_comb begin
    rdata = '0;
    if (sel && rd_en) begin
      case (mode)
        MEM_B:   rdata = {{24{shifted[7]}}, shifted[7:0]};
        MEM_BU:  rdata = {24'b0, shifted[7:0]};
        MEM_H:   rdata = off[0] ? 32'b0 : {{16{shifted[15]}}, shifted};
        MEM_HU:  rdata = off[0] ? 32'b0 : {16'b0, shifted};
        MEM_W:   rdata = (off == 2'b00) ? word : 32'b0;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - randomized bench for clint_timer against a byte-level reference model
module tb_clint_timer;

`ifdef CLINT_PRESCALER_EN
  localparam bit HAS_PRE = 1'b1;
`else
  localparam bit HAS_PRE = 1'b0;
`endif

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel, rd_en, wr_en;
  logic [4:0]  addr;
  logic [2:0]  mem_acc_mode;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        timer_interrupt;

  always #5 clk = ~clk;

  clint_timer dut (
    .clk             (clk),
    .rst             (rst),
    .sel             (sel),
    .rd_en           (rd_en),
    .wr_en           (wr_en),
    .addr            (addr),
    .mem_acc_mode    (mem_acc_mode),
    .wdata           (wdata),
    .rdata           (rdata),
    .timer_interrupt (timer_interrupt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain architectural values, updated once per clock edge.
  logic [63:0] m_mtime, m_cmp;
  logic        m_en, m_irq;
  logic [31:0] m_pre;
  int unsigned m_div;

  function automatic void model_reset();
    m_mtime = 64'd0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en    = 1'b0;
    m_irq   = 1'b0;
    m_pre   = 32'd0;
    m_div   = 0;
  endfunction

  function automatic logic [31:0] m_word(input int idx);
    case (idx)
      0:       return m_mtime[31:0];
      1:       return m_mtime[63:32];
      2:       return m_cmp[31:0];
      3:       return m_cmp[63:32];
      4:       return {31'b0, m_en};
      5:       return m_pre;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int msize(input logic [2:0] m);
    case (m)
      LB, LBU: return 1;
      LH, LHU: return 2;
      LW:      return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [4:0] a, input logic [2:0] m);
    int ai = int'(a);
    int sz = msize(m);
    logic [63:0] v;
    if (sz == 0) return 32'd0;
    if (ai % sz != 0) return 32'd0;
    v = (64'(m_word(ai / 4)) >> (8 * (ai % 4))) % (64'd1 << (8 * sz));
    if ((m == LB || m == LH) && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic void model_edge(input bit s, input bit w, input logic [4:0] a,
                                     input logic [2:0] m, input logic [31:0] d);
    int ai = int'(a);
    int sz = (m == LB || m == LH || m == LW) ? msize(m) : 0;
    bit en_old = m_en;
    bit tick = m_en && (HAS_PRE ? (m_div == m_pre) : 1'b1);
    bit irq_n = m_en && (m_mtime >= m_cmp);
    bit wrote_mt = 1'b0;
    bit wrote_pre = 1'b0;
    logic [31:0] nw;
    if (s && w && sz != 0 && ai % sz == 0) begin
      nw = m_word(ai / 4);
      for (int k = 0; k < sz; k++) nw[8 * (ai % 4 + k) +: 8] = d[8 * k +: 8];
      case (ai / 4)
        0: begin m_mtime[31:0]  = nw; wrote_mt = 1'b1; end
        1: begin m_mtime[63:32] = nw; wrote_mt = 1'b1; end
        2: m_cmp[31:0]  = nw;
        3: m_cmp[63:32] = nw;
        4: m_en = nw[0];
        5: if (HAS_PRE) begin m_pre = nw & 32'h0000_FFFF; wrote_pre = 1'b1; end
        default: ;
      endcase
    end
    if (!wrote_mt && tick) m_mtime = m_mtime + 64'd1;
    if (!en_old || wrote_pre || tick) m_div = 0;
    else m_div = m_div + 1;
    m_irq = irq_n;
  endfunction

  logic [31:0] last_rdata;
  logic        last_irq;

  task automatic do_cycle(input bit s, input bit r, input bit w, input logic [4:0] a,
                          input logic [2:0] m, input logic [31:0] d);
    @(negedge clk);
    sel = s; rd_en = r; wr_en = w; addr = a; mem_acc_mode = m; wdata = d;
    #2;
    last_rdata = rdata;
    last_irq   = timer_interrupt;
    check("rdata", rdata, (s && r) ? m_load(a, m) : 32'd0);
    check("irq", timer_interrupt, m_irq);
    @(posedge clk);
    model_edge(s, w, a, m, d);
  endtask

  task automatic sw(input logic [4:0] a, input logic [31:0] d);
    do_cycle(1'b1, 1'b0, 1'b1, a, LW, d);
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] m);
    do_cycle(1'b1, 1'b1, 1'b0, a, m, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    sel = 1'b1; rd_en = 1'b1; wr_en = 1'b0; mem_acc_mode = LW;
    addr = 5'h00; #1; check("rst_mtime_lo", rdata, 32'h0);
    addr = 5'h04; #1; check("rst_mtime_hi", rdata, 32'h0);
    addr = 5'h08; #1; check("rst_cmp_lo", rdata, 32'hFFFF_FFFF);
    addr = 5'h0C; #1; check("rst_cmp_hi", rdata, 32'hFFFF_FFFF);
    check("rst_irq", timer_interrupt, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit found;
    rst = 1'b0; sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    addr = '0; mem_acc_mode = LW; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    rd(5'h00, LW); check("reset_mtime_lo", last_rdata, 32'h0);
    rd(5'h0C, LW); check("reset_cmp_hi", last_rdata, 32'hFFFF_FFFF);
    rd(5'h10, LW); check("reset_ctrl", last_rdata, 32'h0);

    // Compare and interrupt latency
    sw(5'h08, 32'd10); sw(5'h0C, 32'd0); sw(5'h14, 32'd0); sw(5'h10, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(5'h00, LW);
      if (last_rdata == 32'd10) found = 1'b1;
    end
    check("cmp_reached", found, 1'b1);
    check("irq_before", last_irq, 1'b0);
    rd(5'h00, LW); check("irq_rise", last_irq, 1'b1);
    sw(5'h08, 32'd100);
    rd(5'h00, LW); check("irq_hold", last_irq, 1'b1);
    rd(5'h00, LW); check("irq_fall", last_irq, 1'b0);
    sw(5'h08, 32'd0);
    rd(5'h00, LW); rd(5'h00, LW); check("irq_rearm", last_irq, 1'b1);
    apply_reset();

    // Byte lanes
    sw(5'h08, 32'd0);
    do_cycle(1'b1, 1'b0, 1'b1, 5'h09, LB, 32'h0000_00AB);
    rd(5'h08, LW);  check("sb_lw", last_rdata, 32'h0000_AB00);
    rd(5'h09, LB);  check("sb_lb", last_rdata, 32'hFFFF_FFAB);
    rd(5'h09, LBU); check("sb_lbu", last_rdata, 32'h0000_00AB);
    do_cycle(1'b1, 1'b0, 1'b1, 5'h09, LH, 32'h0000_1234);
    rd(5'h08, LW);  check("sh_misaligned", last_rdata, 32'h0000_AB00);
    rd(5'h0A, LHU); check("lhu_hi", last_rdata, 32'h0000_0000);

    // Carry and store-vs-tick
    sw(5'h10, 32'd0); sw(5'h00, 32'hFFFF_FFFF); sw(5'h04, 32'd0); sw(5'h14, 32'd0);
    sw(5'h10, 32'd1); sw(5'h10, 32'd0);
    rd(5'h04, LW); check("carry_hi", last_rdata, 32'd1);
    rd(5'h00, LW); check("carry_lo", last_rdata, 32'd0);
    sw(5'h10, 32'd1); sw(5'h00, 32'h55);
    rd(5'h00, LW); check("store_vs_tick", last_rdata, 32'h55);
    rd(5'h04, LW); check("store_vs_tick_hi", last_rdata, 32'd1);

    // Prescaler rate
    sw(5'h10, 32'd0); sw(5'h00, 32'd0); sw(5'h04, 32'd0); sw(5'h14, 32'd3);
    rd(5'h14, LW); check("pre_read", last_rdata, HAS_PRE ? 32'd3 : 32'd0);
    sw(5'h10, 32'd1);
    repeat (12) rd(5'h00, LW);
    rd(5'h00, LW); check("pre_rate", last_rdata, HAS_PRE ? 32'd3 : 32'd12);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      bit s, r, w;
      logic [4:0] a;
      logic [2:0] m;
      logic [31:0] d;
      if (i == 1200) apply_reset();
      s = ($urandom % 8) != 0;
      r = $urandom % 2;
      w = ($urandom % 3) == 0;
      a = 5'($urandom % 32);
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      case ($urandom % 10)
        0:       m = 3'($urandom % 8);
        1, 2:    m = LB;
        3:       m = LH;
        4:       m = LBU;
        5:       m = LHU;
        default: m = LW;
      endcase
      case ($urandom % 4)
        0:       d = $urandom;
        1:       d = 32'hFFFF_FFFF;
        default: d = 32'($urandom_range(0, 20));
      endcase
      do_cycle(s, r, w, a, m, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer that answers the core's load/store port and drives `timer_interrupt` into the CSR unit. It sits on the data-side bus beside `data_mem`. The top-level address decode asserts `sel` for its 32-byte window. The block keeps a 64-bit free-running `mtime`, a 64-bit `mtimecmp`, a control register and an optional tick prescaler. It raises a registered level interrupt while enabled and `mtime >= mtimecmp`.

## Interface
- `RST_MTIMECMP`, default `64'hFFFF_FFFF_FFFF_FFFF`: reset value of `mtimecmp`.
- `PRESCALE_W`, default 16: width of the prescale register and divider counter.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous and active-low.
- `sel` in 1: window select from the top-level decode.
- `rd_en` in 1: load strobe, same as `data_mem`.
- `wr_en` in 1: store strobe.
- `addr` in 5: byte offset within the window, taken from `opr_res[4:0]`.
- `mem_acc_mode` in 3: funct3 encoding. 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- `wdata` in 32: store data from `rdata2`, right-aligned.
- `rdata` out 32: load data, extended according to the access mode.
- `timer_interrupt` out 1: level interrupt to `csr_reg`.

## Operation
- Register map (word offsets):
  - 0x00 `MTIME_LO`
  - 0x04 `MTIME_HI`
  - 0x08 `MTIMECMP_LO`
  - 0x0C `MTIMECMP_HI`
  - 0x10 `CTRL`: bit0 `en`, bits[31:1] read as 0.
  - 0x14 `PRESCALE`
  - 0x18 and 0x1C: read 0, writes ignored.
- Reset values:
  - `mtime` = 0, `mtimecmp` = `RST_MTIMECMP`, `CTRL` = 0, `PRESCALE` = 0.
  - Divider counter = 0, `timer_interrupt` = 0.
- Tick:
  - While `en` = 1, the divider counts up to `PRESCALE`, then wraps to 0 and emits a one-cycle tick.
  - Each tick increments `mtime` by 1 as a full 64-bit add with carry into HI. `mtime` wraps from all-ones to 0.
  - While `en` = 0, the divider holds at 0 and `mtime` holds.
- Stores (`sel` & `wr_en`) update only the addressed byte lanes:
  - sb uses lane `addr[1:0]`, taking `wdata[7:0]`.
  - sh uses lanes {`addr[1]`,0} and {`addr[1]`,1}, taking `wdata[15:0]`.
  - sw uses all four lanes.
  - Misaligned sh (`addr[0]`=1) and misaligned sw (`addr[1:0]`≠0) are ignored.
- Loads (`sel` & `rd_en`):
  - The addressed word is shifted right by the byte offset.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw returns the full word.
  - Misaligned lh, lhu or lw returns 0.
- `rdata` = 0 whenever `sel` & `rd_en` is low.
- Simultaneous store to `MTIME_LO` or `MTIME_HI` and a tick in the same cycle:
  - The stored lanes take the written value.
  - The untouched half keeps its old value, with no increment and no carry that cycle.
- A store to `PRESCALE` resets the divider counter to 0.
- `timer_interrupt` is a register. At every edge it samples `en && (mtime >= mtimecmp)`, an unsigned 64-bit compare of the current register values.
- The interrupt is level-only. Software clears it by raising `mtimecmp` or clearing `en`.

## Timing
- Loads are combinational, so `rdata` is valid in the same cycle as `addr`. This matches the single-cycle core.
- Stores commit at the rising edge where `sel` & `wr_en` is 1.
- Interrupt latency:
  - If `mtime` becomes ≥ `mtimecmp` at edge N, `timer_interrupt` rises at edge N+1.
  - A store to `mtimecmp` or `CTRL` at edge N is reflected in `timer_interrupt` at edge N+1.
- Asserting `rst` mid-operation immediately forces every register and `timer_interrupt` to its reset value, independent of `clk`. On release, the first tick occurs `PRESCALE`+1 enabled cycles after `en` is set.

## Configuration
- Macro `CLINT_PRESCALER_EN`.
- Defined: the divider and `PRESCALE` register are present, as described above.
- Undefined:
  - The tick is every cycle while `en` = 1.
  - `PRESCALE` reads 0 and stores to it are ignored.
  - The divider logic is absent and `PRESCALE_W` is unused.

## Structure
- `clint_pkg` holds:
  - register offset localparams;
  - the `mem_acc_mode` enum, which `data_mem` and `controller` also use;
  - the CTRL bit index.
- Sub-module `clint_prescaler` contains the divider counter and tick generation. It is instantiated only under `CLINT_PRESCALER_EN`.
- The top module holds the registers, the byte-lane write logic, load extension and the compare/interrupt register.

## Test plan
- Reset: drive `rst` = 0 mid-count.
  - Response: `MTIME` reads 0/0, `MTIMECMP` reads FFFFFFFF/FFFFFFFF, `timer_interrupt` = 0 in the same cycle.
- Compare: sw `MTIMECMP_LO` = 10, sw `MTIMECMP_HI` = 0, `PRESCALE` = 0, sw `CTRL` = 1.
  - Response: `timer_interrupt` rises exactly one cycle after `MTIME_LO` reads 10.
  - Then sw `MTIMECMP_LO` = 100: `timer_interrupt` falls one cycle after the store edge.
- Byte lanes: sw `MTIMECMP_LO` = 0, then sb 0xAB to offset 0x09.
  - Response: lw @0x08 returns 0x0000AB00; lb @0x09 returns 0xFFFFFFAB; lbu @0x09 returns 0x000000AB.
  - sh to 0x09 leaves the register unchanged.
- Carry: with `en` = 0, sw `MTIME_LO` = 0xFFFFFFFF and sw `MTIME_HI` = 0, then set `en` = 1.
  - Response: after one tick, `HI` = 1 and `LO` = 0.
  - A store to `MTIME_LO` coinciding with a tick leaves exactly the stored value.
- Prescaler (macro defined): `PRESCALE` = 3.
  - Response: `mtime` increments once every 4 cycles.
  - With the macro undefined, `PRESCALE` reads 0 and `mtime` increments every cycle.
